// File: rtl/carregador_memoria_dados.sv
// carregador_memoria_dados: loads the 128x32 data memory from the UART byte stream.
// Frame: count byte N (0 means 128, >128 clamped to 128), then 4*N data bytes, MSB first.
// Each assembled word is written with a one-cycle strobe; ocupado stalls the processor.
// Optional feature macro VERIFICA_SOMA_EN: a trailing checksum byte (sum mod 256 of the
// data bytes) is required; a mismatch sets erro instead of concluido.
module carregador_memoria_dados #(
  parameter int unsigned ENDERECO_BASE  = 0,
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valido,
  input  logic [7:0]  byte_rx,
  output logic        sinal_escrever,
  output logic [6:0]  endereco,
  output logic [31:0] dado_escrever,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro,
  output logic [7:0]  palavras
);

  localparam logic [6:0] EnderecoInicial = 7'(ENDERECO_BASE % 128);
  localparam int unsigned LarguraTempo = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [LarguraTempo-1:0] LimiteTempo = LarguraTempo'(TIMEOUT_CICLOS);

  typedef enum logic [1:0] {
    EstOcioso    = 2'd0,
    EstRecebendo = 2'd1,
    EstConcluido = 2'd2
`ifdef VERIFICA_SOMA_EN
    , EstSoma    = 2'd3
`endif
  } estado_e;

  estado_e                 estado_q, estado_d;
  logic [1:0]              indice_q, indice_d;
  logic [23:0]             deslocamento_q, deslocamento_d;
  logic [7:0]              total_q, total_d;
  logic [7:0]              contador_q, contador_d;
  logic [LarguraTempo-1:0] tempo_q, tempo_d;
  logic                    sinal_escrever_q, sinal_escrever_d;
  logic [6:0]              endereco_q, endereco_d;
  logic [31:0]             dado_q, dado_d;
  logic                    ocupado_q, ocupado_d;
  logic                    concluido_q, concluido_d;
  logic                    erro_q, erro_d;
  logic [7:0]              palavras_q, palavras_d;
`ifdef VERIFICA_SOMA_EN
  logic [7:0]              soma_q, soma_d;
`endif

  logic em_transferencia;
  logic tempo_esgotado;

  // Timeout watchdog is only armed while bytes of a frame are expected.
  always_comb begin
`ifdef VERIFICA_SOMA_EN
    em_transferencia = (estado_q == EstRecebendo) || (estado_q == EstSoma);
`else
    em_transferencia = (estado_q == EstRecebendo);
`endif
    tempo_esgotado = em_transferencia && (tempo_q == LimiteTempo);
  end

  // Next-state and registered-output logic for the loader FSM.
  always_comb begin
    estado_d         = estado_q;
    indice_d         = indice_q;
    deslocamento_d   = deslocamento_q;
    total_d          = total_q;
    contador_d       = contador_q;
    tempo_d          = tempo_q;
    sinal_escrever_d = 1'b0;
    endereco_d       = endereco_q;
    dado_d           = dado_q;
    ocupado_d        = ocupado_q;
    concluido_d      = concluido_q;
    erro_d           = erro_q;
    palavras_d       = palavras_q;
`ifdef VERIFICA_SOMA_EN
    soma_d           = soma_q;
`endif

    // The cycle after a strobe: advance address and word count.
    if (sinal_escrever_q) begin
      endereco_d = endereco_q + 7'd1;
      palavras_d = palavras_q + 8'd1;
`ifndef VERIFICA_SOMA_EN
      // Last word written: release the processor together with the final count.
      if (estado_q == EstConcluido) begin
        ocupado_d   = 1'b0;
        concluido_d = 1'b1;
      end
`endif
    end

    case (estado_q)
      EstOcioso, EstConcluido: begin
        // A count byte starts a new frame and overrides any pending post-strobe update.
        if (byte_valido) begin
          total_d     = (byte_rx == 8'd0 || byte_rx > 8'd128) ? 8'd128 : byte_rx;
          contador_d  = 8'd0;
          palavras_d  = 8'd0;
          endereco_d  = EnderecoInicial;
          indice_d    = 2'd0;
          tempo_d     = '0;
          concluido_d = 1'b0;
          erro_d      = 1'b0;
          ocupado_d   = 1'b1;
`ifdef VERIFICA_SOMA_EN
          soma_d      = 8'd0;
`endif
          estado_d    = EstRecebendo;
        end
      end

      EstRecebendo: begin
        if (tempo_esgotado) begin
          // Timeout beats a simultaneous byte; the partial word is dropped.
          erro_d    = 1'b1;
          ocupado_d = 1'b0;
          indice_d  = 2'd0;
          tempo_d   = '0;
          estado_d  = EstOcioso;
        end else if (byte_valido) begin
          tempo_d        = '0;
          deslocamento_d = {deslocamento_q[15:0], byte_rx};
`ifdef VERIFICA_SOMA_EN
          soma_d         = soma_q + byte_rx;
`endif
          if (indice_q == 2'd3) begin
            indice_d         = 2'd0;
            sinal_escrever_d = 1'b1;
            dado_d           = {deslocamento_q, byte_rx};
            contador_d       = contador_q + 8'd1;
            if (contador_q + 8'd1 == total_q) begin
`ifdef VERIFICA_SOMA_EN
              estado_d = EstSoma;
`else
              estado_d = EstConcluido;
`endif
            end
          end else begin
            indice_d = indice_q + 2'd1;
          end
        end else begin
          tempo_d = tempo_q + 1'b1;
        end
      end

`ifdef VERIFICA_SOMA_EN
      EstSoma: begin
        if (tempo_esgotado) begin
          erro_d    = 1'b1;
          ocupado_d = 1'b0;
          tempo_d   = '0;
          estado_d  = EstOcioso;
        end else if (byte_valido) begin
          tempo_d   = '0;
          ocupado_d = 1'b0;
          if (byte_rx == soma_q) begin
            concluido_d = 1'b1;
            estado_d    = EstConcluido;
          end else begin
            erro_d   = 1'b1;
            estado_d = EstOcioso;
          end
        end else begin
          tempo_d = tempo_q + 1'b1;
        end
      end
`endif

      default: estado_d = EstOcioso;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q         <= EstOcioso;
      indice_q         <= 2'd0;
      deslocamento_q   <= 24'd0;
      total_q          <= 8'd0;
      contador_q       <= 8'd0;
      tempo_q          <= '0;
      sinal_escrever_q <= 1'b0;
      endereco_q       <= EnderecoInicial;
      dado_q           <= 32'd0;
      ocupado_q        <= 1'b0;
      concluido_q      <= 1'b0;
      erro_q           <= 1'b0;
      palavras_q       <= 8'd0;
`ifdef VERIFICA_SOMA_EN
      soma_q           <= 8'd0;
`endif
    end else begin
      estado_q         <= estado_d;
      indice_q         <= indice_d;
      deslocamento_q   <= deslocamento_d;
      total_q          <= total_d;
      contador_q       <= contador_d;
      tempo_q          <= tempo_d;
      sinal_escrever_q <= sinal_escrever_d;
      endereco_q       <= endereco_d;
      dado_q           <= dado_d;
      ocupado_q        <= ocupado_d;
      concluido_q      <= concluido_d;
      erro_q           <= erro_d;
      palavras_q       <= palavras_d;
`ifdef VERIFICA_SOMA_EN
      soma_q           <= soma_d;
`endif
    end
  end

  assign sinal_escrever = sinal_escrever_q;
  assign endereco       = endereco_q;
  assign dado_escrever  = dado_q;
  assign ocupado        = ocupado_q;
  assign concluido      = concluido_q;
  assign erro           = erro_q;
  assign palavras       = palavras_q;

endmodule

// File: tb/tb_carregador_memoria_dados.sv
// Self-checking bench for carregador_memoria_dados (default build, or with VERIFICA_SOMA_EN).
module tb_carregador_memoria_dados;

  localparam int unsigned Timeout = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        byte_valido;
  logic [7:0]  byte_rx;

  logic        sinal_escrever_a, ocupado_a, concluido_a, erro_a;
  logic [6:0]  endereco_a;
  logic [31:0] dado_a;
  logic [7:0]  palavras_a;

  logic        sinal_escrever_b, ocupado_b, concluido_b, erro_b;
  logic [6:0]  endereco_b;
  logic [31:0] dado_b;
  logic [7:0]  palavras_b;

  carregador_memoria_dados #(.ENDERECO_BASE(0), .TIMEOUT_CICLOS(Timeout)) dut_a (
    .clock(clock), .reset(reset), .byte_valido(byte_valido), .byte_rx(byte_rx),
    .sinal_escrever(sinal_escrever_a), .endereco(endereco_a), .dado_escrever(dado_a),
    .ocupado(ocupado_a), .concluido(concluido_a), .erro(erro_a), .palavras(palavras_a)
  );

  carregador_memoria_dados #(.ENDERECO_BASE(126), .TIMEOUT_CICLOS(Timeout)) dut_b (
    .clock(clock), .reset(reset), .byte_valido(byte_valido), .byte_rx(byte_rx),
    .sinal_escrever(sinal_escrever_b), .endereco(endereco_b), .dado_escrever(dado_b),
    .ocupado(ocupado_b), .concluido(concluido_b), .erro(erro_b), .palavras(palavras_b)
  );

  always #5 clock = ~clock;

  function automatic logic [50:0] empacota(input logic s, input logic [6:0] e,
                                           input logic [31:0] d, input logic o,
                                           input logic c, input logic r,
                                           input logic [7:0] p);
    return {s, e, d, o, c, r, p};
  endfunction

  logic [50:0] saida_a;
  assign saida_a = empacota(sinal_escrever_a, endereco_a, dado_a, ocupado_a, concluido_a,
                            erro_a, palavras_a);

  typedef struct {
    logic        valido;
    logic [7:0]  dado;
    logic [50:0] esperado;
  } vetor_t;

  vetor_t tabela[$];
  int checks = 0;
  int passes = 0;
  int strobes_a = 0;
  int strobes_b = 0;
  logic [6:0] enderecos_b[$];

  // Strobes are sampled mid-cycle so each one-cycle pulse counts once.
  always @(negedge clock) begin
    if (sinal_escrever_a) strobes_a++;
    if (sinal_escrever_b) begin
      strobes_b++;
      enderecos_b.push_back(endereco_b);
    end
  end

  task automatic verifica(input string nome, input logic [63:0] atual,
                          input logic [63:0] esperado);
    checks++;
    if (atual === esperado) passes++;
    else $display("FAIL %s: got %h expected %h", nome, atual, esperado);
  endtask

  task automatic adiciona(input logic v, input logic [7:0] b, input logic s,
                          input logic [6:0] e, input logic [31:0] d, input logic o,
                          input logic c, input logic r, input logic [7:0] p);
    vetor_t t;
    t.valido   = v;
    t.dado     = b;
    t.esperado = empacota(s, e, d, o, c, r, p);
    tabela.push_back(t);
  endtask

  // One clock: drive inputs after the edge, let the next edge consume them.
  task automatic passo(input logic v, input logic [7:0] b);
    byte_valido = v;
    byte_rx     = b;
    @(posedge clock);
    #1;
    byte_valido = 1'b0;
  endtask

  initial begin
    logic [50:0] repouso;
    repouso = empacota(1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Frame 1: single word
    adiciona(1, 8'h01, 0, 0, 32'h0, 1, 0, 0, 0);
    adiciona(1, 8'h12, 0, 0, 32'h0, 1, 0, 0, 0);
    adiciona(1, 8'h34, 0, 0, 32'h0, 1, 0, 0, 0);
    adiciona(1, 8'h56, 0, 0, 32'h0, 1, 0, 0, 0);
    adiciona(1, 8'h78, 1, 0, 32'h12345678, 1, 0, 0, 0);
`ifdef VERIFICA_SOMA_EN
    adiciona(0, 8'h00, 0, 1, 32'h12345678, 1, 0, 0, 1);
    adiciona(1, 8'h14, 0, 1, 32'h12345678, 0, 1, 0, 1);
`else
    adiciona(0, 8'h00, 0, 1, 32'h12345678, 0, 1, 0, 1);
`endif
    adiciona(0, 8'h00, 0, 1, 32'h12345678, 0, 1, 0, 1);
    // Frame 2: two words back-to-back
    adiciona(1, 8'h02, 0, 0, 32'h12345678, 1, 0, 0, 0);
    adiciona(1, 8'hDE, 0, 0, 32'h12345678, 1, 0, 0, 0);
    adiciona(1, 8'hAD, 0, 0, 32'h12345678, 1, 0, 0, 0);
    adiciona(1, 8'hBE, 0, 0, 32'h12345678, 1, 0, 0, 0);
    adiciona(1, 8'hEF, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
    adiciona(1, 8'hCA, 0, 1, 32'hDEADBEEF, 1, 0, 0, 1);
    adiciona(1, 8'hFE, 0, 1, 32'hDEADBEEF, 1, 0, 0, 1);
    adiciona(1, 8'hBA, 0, 1, 32'hDEADBEEF, 1, 0, 0, 1);
    adiciona(1, 8'hBE, 1, 1, 32'hCAFEBABE, 1, 0, 0, 1);
`ifdef VERIFICA_SOMA_EN
    adiciona(0, 8'h00, 0, 2, 32'hCAFEBABE, 1, 0, 0, 2);
    adiciona(1, 8'h78, 0, 2, 32'hCAFEBABE, 0, 1, 0, 2);
`else
    adiciona(0, 8'h00, 0, 2, 32'hCAFEBABE, 0, 1, 0, 2);
`endif
    adiciona(0, 8'h00, 0, 2, 32'hCAFEBABE, 0, 1, 0, 2);

    reset       = 1'b1;
    byte_valido = 1'b0;
    byte_rx     = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    verifica("reset_a", 64'(saida_a), 64'(repouso));
    verifica("reset_b_endereco", 64'(endereco_b), 64'd126);
    reset = 1'b0;
    strobes_a = 0;

    for (int i = 0; i < tabela.size(); i++) begin
      passo(tabela[i].valido, tabela[i].dado);
      verifica($sformatf("vec%0d", i), 64'(saida_a), 64'(tabela[i].esperado));
    end
    verifica("strobes_frames_1_2", 64'(strobes_a), 64'd3);

    // Address wrap on the instance based at 126
    enderecos_b.delete();
    strobes_b = 0;
    passo(1, 8'h03);
    for (int i = 0; i < 12; i++) passo(1, 8'(i));
`ifdef VERIFICA_SOMA_EN
    passo(1, 8'h42);
`endif
    repeat (3) passo(0, 8'h00);
    verifica("wrap_strobes", 64'(strobes_b), 64'd3);
    verifica("wrap_end0", 64'(enderecos_b.size() > 0 ? enderecos_b[0] : 7'h7F), 64'd126);
    verifica("wrap_end1", 64'(enderecos_b.size() > 1 ? enderecos_b[1] : 7'h7F), 64'd127);
    verifica("wrap_end2", 64'(enderecos_b.size() > 2 ? enderecos_b[2] : 7'h7F), 64'd0);
    verifica("wrap_palavras", 64'(palavras_b), 64'd3);
    verifica("wrap_concluido", 64'({concluido_b, ocupado_b, endereco_b}), 64'({2'b10, 7'd1}));

    // Timeout after 5 of 8 data bytes
    strobes_a = 0;
    passo(1, 8'h02);
    passo(1, 8'h11); passo(1, 8'h22); passo(1, 8'h33); passo(1, 8'h44); passo(1, 8'h55);
    repeat (15) passo(0, 8'h00);
    verifica("timeout_not_yet", 64'({erro_a, ocupado_a}), 64'(2'b01));
    repeat (10) passo(0, 8'h00);
    verifica("timeout_flags", 64'({erro_a, ocupado_a, concluido_a}), 64'(3'b100));
    verifica("timeout_strobes", 64'(strobes_a), 64'd1);
    verifica("timeout_palavras", 64'(palavras_a), 64'd1);
    passo(1, 8'h01);
    verifica("timeout_clear", 64'({erro_a, ocupado_a}), 64'(2'b01));
    passo(1, 8'h9A); passo(1, 8'hBC); passo(1, 8'hDE); passo(1, 8'hF0);
    verifica("after_timeout_word", 64'({sinal_escrever_a, dado_a}), 64'({1'b1, 32'h9ABCDEF0}));
`ifdef VERIFICA_SOMA_EN
    passo(1, 8'h24);
`endif
    repeat (2) passo(0, 8'h00);
    verifica("after_timeout_done", 64'({concluido_a, erro_a, ocupado_a}), 64'(3'b100));

`ifdef VERIFICA_SOMA_EN
    // Checksum good then bad
    passo(1, 8'h01);
    passo(1, 8'h01); passo(1, 8'h02); passo(1, 8'h03); passo(1, 8'h04);
    passo(0, 8'h00);
    passo(1, 8'h0A);
    passo(0, 8'h00);
    verifica("soma_ok", 64'({concluido_a, erro_a, ocupado_a}), 64'(3'b100));
    strobes_a = 0;
    passo(1, 8'h01);
    passo(1, 8'h01); passo(1, 8'h02); passo(1, 8'h03); passo(1, 8'h04);
    passo(0, 8'h00);
    passo(1, 8'h0B);
    passo(0, 8'h00);
    verifica("soma_bad", 64'({concluido_a, erro_a, ocupado_a}), 64'(3'b010));
    verifica("soma_bad_write", 64'({strobes_a, dado_a}), 64'({32'd1, 32'h01020304}));
`endif

    // Reset mid-frame
    passo(1, 8'h01);
    passo(1, 8'hAA);
    passo(1, 8'hBB);
    strobes_a = 0;
    reset = 1'b1;
    passo(0, 8'h00);
    verifica("midreset_a", 64'(saida_a), 64'(repouso));
    verifica("midreset_b_endereco", 64'(endereco_b), 64'd126);
    reset = 1'b0;
    repeat (3) passo(0, 8'h00);
    verifica("midreset_idle", 64'(saida_a), 64'(repouso));
    verifica("midreset_strobes", 64'(strobes_a), 64'd0);
    passo(1, 8'h01);
    passo(1, 8'hA1); passo(1, 8'hB2); passo(1, 8'hC3); passo(1, 8'hD4);
    verifica("fresh_word", 64'(saida_a), 64'(empacota(1, 0, 32'hA1B2C3D4, 1, 0, 0, 0)));
`ifdef VERIFICA_SOMA_EN
    passo(0, 8'h00);
    passo(1, 8'hEA);
`endif
    repeat (2) passo(0, 8'h00);
    verifica("fresh_done", 64'(saida_a), 64'(empacota(0, 1, 32'hA1B2C3D4, 0, 1, 0, 1)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/carregador_memoria_dados.md
Name: carregador_memoria_dados

Overview:
- Upstream feeder of the 128x32 data memory.
- Consumes the byte stream from the UART receiver and assembles big-endian 32-bit words.
- Issues one-cycle write strobes with address and data straight onto the data memory write port (sinal_escrever, endereco, dado_escrever).
- Holds ocupado high while loading so the processor can be stalled; flags completion, timeout and (optionally) checksum errors.

Parameters:
- ENDERECO_BASE, 0, first word address written; subsequent addresses increment modulo 128.
- TIMEOUT_CICLOS, 50000, max clock cycles allowed between consecutive bytes during a transfer; must be >= 2.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- byte_valido  input  1  one-cycle strobe: byte_rx holds a received byte
- byte_rx  input  8  received UART byte
- sinal_escrever  output  1  one-cycle write strobe to data memory
- endereco  output  7  word address for the write
- dado_escrever  output  32  assembled word
- ocupado  output  1  high while a transfer is in progress
- concluido  output  1  high after a transfer completes successfully
- erro  output  1  sticky error flag (timeout or checksum)
- palavras  output  8  count of words written in the current/last transfer (0..128)

Behaviour:
- Interface: single clock, clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: sinal_escrever=0, endereco=ENDERECO_BASE, dado_escrever=0, ocupado=0, concluido=0, erro=0, palavras=0, state OCIOSO, byte index 0, timeout counter 0.
- Frame format: count byte N (1..255 = N words; 0 = 128 words), then 4*N data bytes, MSB first. With VERIFICA_SOMA_EN, one checksum byte follows the data bytes.
- N > 128: clamp to 128. Bytes beyond 128 words are never written.
- States:
  - OCIOSO: byte_valido -> latch N, palavras=0, endereco=ENDERECO_BASE, byte index 0, clear concluido and erro, ocupado=1 -> RECEBENDO.
  - RECEBENDO: each byte_valido shifts byte_rx into the word shift register at index 0..3 and resets the timeout counter. On index 3:
    - next cycle: sinal_escrever=1 for exactly one cycle; dado_escrever = {b0,b1,b2,b3}; endereco = current address.
    - following cycle: endereco increments mod 128; palavras increments.
    - When the last word's strobe issues: -> SOMA if the feature is enabled, else CONCLUIDO.
  - SOMA (feature only): next byte_valido is compared with the 8-bit sum mod 256 of all data bytes. Match -> CONCLUIDO; mismatch -> erro=1, OCIOSO.
  - CONCLUIDO: ocupado=0, concluido=1. A new byte_valido behaves as in OCIOSO and starts a new transfer.
- Timeout: counter runs in RECEBENDO/SOMA and increments each cycle without byte_valido. Reaching TIMEOUT_CICLOS -> erro=1, ocupado=0, partial word discarded, -> OCIOSO. Words already written are not undone.
- byte_valido in the same cycle the timeout fires: the timeout wins and the byte is dropped.
- byte_valido in the cycle the write strobe is high: the byte is accepted normally (back-to-back bytes are legal, 1 byte/cycle max).
- Address wrap: ENDERECO_BASE=120 with N=16 writes 120..127, then 0..7.
- reset mid-transfer: everything returns to reset values next edge; no further strobes.
- erro is sticky until the next count byte is accepted or reset.

Optional Feature:
- Macro: VERIFICA_SOMA_EN.
- Defined: SOMA state present; a checksum byte is required after data; mismatch sets erro and concluido stays 0. Words are still written before the check.
- Undefined: no SOMA state and no sum register; a transfer completes directly after the last write strobe.

Test Plan:
- Reset, then bytes 01,12,34,56,78 -> one strobe with endereco=0, dado_escrever=0x12345678; then concluido=1, palavras=1, ocupado=0.
- N=02, words DEADBEEF,CAFEBABE sent back-to-back (1 byte/cycle) -> strobes at addresses 0 and 1 with correct data, each strobe 1 cycle wide, no dropped bytes.
- ENDERECO_BASE=126, N=03 -> writes at 126, 127, 0; palavras=3.
- N=02, 5 data bytes then idle for TIMEOUT_CICLOS cycles -> one write only, erro=1, ocupado=0, no second strobe; next count byte clears erro.
- VERIFICA_SOMA_EN, N=01, data 01 02 03 04, checksum 0A -> concluido=1. Same data with checksum 0B -> erro=1, concluido=0, and the word was still written.
- reset asserted after 2 data bytes of a frame -> no strobe; all outputs at reset values; a fresh frame then loads correctly.
